// File: rtl/rhs2116_pkg.sv
// Shared constants, output FSM encoding and packet sizing for the RHS2116 frame packer.
package rhs2116_pkg;

  localparam int          DEF_NUM_CH    = 16;
  localparam int          SAMPLE_W      = 16;
  localparam logic [15:0] DEF_SYNC_WORD = 16'hA5C3;
  localparam logic [15:0] DEF_TRL_WORD  = 16'h5A3C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_TRL  = 2'd3
  } tx_state_e;

  // Header + one word per channel pair + trailer.
  function automatic int pkt_words(input int num_ch);
    return num_ch / 2 + 2;
  endfunction

endpackage

// File: rtl/rhs2116_pkt_tx.sv
// Packet transmitter: latches a complete scan into a shadow buffer and streams
// header, packed sample pairs and checksum trailer over a valid/ready interface.
module rhs2116_pkt_tx
  import rhs2116_pkg::*;
#(
  parameter int          NUM_CH    = DEF_NUM_CH,
  parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter logic [15:0] TRL_WORD  = DEF_TRL_WORD
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_load,
  input  logic [NUM_CH*SAMPLE_W-1:0] i_scan,
  input  logic                       i_ready,
  output logic                       o_idle,
  output logic [31:0]                o_data,
  output logic                       o_valid,
  output logic                       o_last,
  output logic [15:0]                o_frame_seq
);

  localparam int            NW     = NUM_CH / 2;
  localparam int            WW     = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(NW - 1);

  tx_state_e                  r_state;
  tx_state_e                  w_state_next;
  logic [WW-1:0]              r_widx;
  logic [WW-1:0]              w_widx_next;
  logic [NUM_CH*SAMPLE_W-1:0] r_shadow;
  logic [15:0]                r_frame_seq;
  logic [15:0]                w_csum;
  logic [31:0]                w_pair [NW];

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_pair
      assign w_pair[gi] = {r_shadow[(2*gi)*SAMPLE_W +: SAMPLE_W],
                           r_shadow[(2*gi+1)*SAMPLE_W +: SAMPLE_W]};
    end
  endgenerate

  // Shadow only changes in IDLE, so the checksum is stable for the whole packet.
  always_comb begin
    w_csum = r_frame_seq;
    for (int i = 0; i < NUM_CH; i++) begin
      w_csum = w_csum + r_shadow[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_widx_next  = r_widx;
    o_valid      = 1'b0;
    o_last       = 1'b0;
    o_data       = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_load) w_state_next = ST_HDR;
      end
      ST_HDR: begin
        o_valid = 1'b1;
        o_data  = {SYNC_WORD, r_frame_seq};
        if (i_ready) begin
          w_state_next = ST_DATA;
          w_widx_next  = '0;
        end
      end
      ST_DATA: begin
        o_valid = 1'b1;
        o_data  = w_pair[r_widx];
        if (i_ready) begin
          if (r_widx == LAST_W) w_state_next = ST_TRL;
          else                  w_widx_next  = r_widx + WW'(1);
        end
      end
      ST_TRL: begin
        o_valid = 1'b1;
        o_last  = 1'b1;
        o_data  = {TRL_WORD, w_csum};
        if (i_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_widx      <= '0;
      r_frame_seq <= '0;
    end else begin
      r_state <= w_state_next;
      r_widx  <= w_widx_next;
      if (r_state == ST_TRL && i_ready) r_frame_seq <= r_frame_seq + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_load && r_state == ST_IDLE) r_shadow <= i_scan;
  end

  assign o_idle      = (r_state == ST_IDLE);
  assign o_frame_seq = r_frame_seq;

endmodule

// File: rtl/rhs2116_frame_packer.sv
// Collects one scan of per-channel SPI results and hands it to the packet
// transmitter; scans completing while a packet is in flight are dropped and counted.
module rhs2116_frame_packer
  import rhs2116_pkg::*;
#(
  parameter int          NUM_CH    = DEF_NUM_CH,
  parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter logic [15:0] TRL_WORD  = DEF_TRL_WORD
) (
  input  logic        i_clk_spi,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [31:0] i_in_data,
  input  logic        i_in_valid,
  output logic [31:0] o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_last,
  output logic [15:0] o_frame_seq,
  output logic [15:0] o_drop_count
);

  localparam int              CH_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]            r_chan_idx;
  logic [SAMPLE_W-1:0]        r_sample_buf [NUM_CH-1];
  logic [15:0]                r_drop_count;
  logic                       w_wr;
  logic                       w_scan_done;
  logic                       w_tx_idle;
  logic                       w_load;
  logic [NUM_CH*SAMPLE_W-1:0] w_scan;
  logic                       w_unused_hi;

  assign w_wr        = i_enable & i_in_valid;
  assign w_scan_done = w_wr && (r_chan_idx == LAST_CH);
  assign w_load      = w_scan_done & w_tx_idle;
  assign w_unused_hi = ^i_in_data[31:16];

  always_ff @(posedge i_clk_spi or posedge i_rst) begin
    if (i_rst) begin
      r_chan_idx <= '0;
    end else if (!i_enable) begin
      r_chan_idx <= '0;
    end else if (i_in_valid) begin
      r_chan_idx <= w_scan_done ? '0 : r_chan_idx + CH_W'(1);
    end
  end

  // The last channel bypasses the buffer and goes straight into the shadow copy.
  always_ff @(posedge i_clk_spi) begin
    if (w_wr && !w_scan_done) r_sample_buf[r_chan_idx] <= i_in_data[SAMPLE_W-1:0];
  end

  generate
    for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_scan
      assign w_scan[gi*SAMPLE_W +: SAMPLE_W] = r_sample_buf[gi];
    end
  endgenerate
  assign w_scan[(NUM_CH-1)*SAMPLE_W +: SAMPLE_W] = i_in_data[SAMPLE_W-1:0];

  always_ff @(posedge i_clk_spi or posedge i_rst) begin
    if (i_rst) begin
      r_drop_count <= '0;
    end else if (w_scan_done && !w_tx_idle && r_drop_count != 16'hFFFF) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  rhs2116_pkt_tx #(
    .NUM_CH    (NUM_CH),
    .SYNC_WORD (SYNC_WORD),
    .TRL_WORD  (TRL_WORD)
  ) u_tx (
    .i_clk       (i_clk_spi),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_scan      (w_scan),
    .i_ready     (i_out_ready),
    .o_idle      (w_tx_idle),
    .o_data      (o_out_data),
    .o_valid     (o_out_valid),
    .o_last      (o_out_last),
    .o_frame_seq (o_frame_seq)
  );

  assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_rhs2116_frame_packer.sv
// Scoreboard bench for rhs2116_frame_packer: expected packets are queued as scans are fed
// and checked word by word at each output handshake.
module tb_rhs2116_frame_packer;
  import rhs2116_pkg::*;

  localparam int NUM_CH = 16;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        enable    = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data   = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic [15:0] frame_seq;
  logic [15:0] drop_count;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  logic [15:0] model_seq = '0;
  bit          mon_en    = 1'b0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_data = '0;

  always #5 clk = ~clk;

  rhs2116_frame_packer #(.NUM_CH(NUM_CH)) dut (
    .i_clk_spi    (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_last   (out_last),
    .o_frame_seq  (frame_seq),
    .o_drop_count (drop_count)
  );

  // Output monitor: pops the scoreboard on each handshake and checks hold stability.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (hold_pend) begin
        n_checks++;
        if (!(out_valid === 1'b1 && out_data === hold_data)) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%b data=%08h, expected valid=1 data=%08h",
                   out_valid, out_data, hold_data);
        end
      end
      hold_pend = (out_valid === 1'b1) && !out_ready;
      hold_data = out_data;
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %08h last=%b, expected no output", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            n_fail++;
            $display("FAIL pkt_word: got %08h last=%b, expected %08h last=%b",
                     out_data, out_last, e.data, e.last);
          end else begin
            $display("rx word %08h last=%b", out_data, out_last);
          end
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic push_packet(input logic [15:0] seq, input logic [15:0] base);
    exp_t        e;
    logic [15:0] sum;
    sum    = seq;
    e.data = {DEF_SYNC_WORD, seq};
    e.last = 1'b0;
    exp_q.push_back(e);
    for (int w = 0; w < pkt_words(NUM_CH) - 2; w++) begin
      e.data = {base + 16'(2*w), base + 16'(2*w + 1)};
      exp_q.push_back(e);
    end
    for (int c = 0; c < NUM_CH; c++) sum = sum + base + 16'(c);
    e.data = {DEF_TRL_WORD, sum};
    e.last = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic feed_word(input logic [15:0] s);
    in_data  = {16'hDEAD, s};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic feed_scan(input logic [15:0] base, input int n);
    for (int c = 0; c < n; c++) feed_word(base + 16'(c));
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 400) begin
      @(posedge clk);
      i++;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
    n_checks++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %08h, expected 0", out_data); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b, expected 0", out_last); end
    n_checks++;
    if (frame_seq !== 16'h0) begin n_fail++; $display("FAIL rst_seq: got %04h, expected 0", frame_seq); end
    n_checks++;
    if (drop_count !== 16'h0) begin n_fail++; $display("FAIL rst_drop: got %04h, expected 0", drop_count); end
    @(posedge clk); #1;
    rst       = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    mon_en    = 1'b1;
  endtask

  task automatic test_basic;
    push_packet(model_seq, 16'h0100);
    feed_scan(16'h0100, NUM_CH);
    wait_drain("basic");
    model_seq++;
    n_checks++;
    if (frame_seq !== model_seq) begin n_fail++; $display("FAIL basic_seq: got %04h, expected %04h", frame_seq, model_seq); end
  endtask

  task automatic test_backpressure;
    push_packet(model_seq, 16'h0100);
    fork
      feed_scan(16'h0100, NUM_CH);
      for (int k = 0; k < 80; k++) begin
        out_ready = ~out_ready;
        @(posedge clk); #1;
      end
    join
    out_ready = 1'b1;
    wait_drain("backpressure");
    model_seq++;
    n_checks++;
    if (frame_seq !== model_seq) begin n_fail++; $display("FAIL bp_seq: got %04h, expected %04h", frame_seq, model_seq); end
  endtask

  task automatic test_drop;
    out_ready = 1'b0;
    push_packet(model_seq, 16'h0100);
    feed_scan(16'h0100, NUM_CH);
    feed_scan(16'h0400, NUM_CH);
    n_checks++;
    if (drop_count !== 16'd1) begin n_fail++; $display("FAIL drop_count: got %0d, expected 1", drop_count); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== {DEF_SYNC_WORD, model_seq}) begin
      n_fail++;
      $display("FAIL drop_hdr_held: got valid=%b data=%08h, expected valid=1 data=%08h",
               out_valid, out_data, {DEF_SYNC_WORD, model_seq});
    end
    out_ready = 1'b1;
    wait_drain("drop");
    model_seq++;
    n_checks++;
    if (frame_seq !== model_seq) begin n_fail++; $display("FAIL drop_seq: got %04h, expected %04h", frame_seq, model_seq); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_extra: got valid=%b, expected 0", out_valid); end
  endtask

  task automatic test_realign;
    feed_scan(16'h0500, 7);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    push_packet(model_seq, 16'h0200);
    feed_scan(16'h0200, NUM_CH);
    wait_drain("realign");
    model_seq++;
    n_checks++;
    if (frame_seq !== model_seq) begin n_fail++; $display("FAIL realign_seq: got %04h, expected %04h", frame_seq, model_seq); end
  endtask

  task automatic test_seq_wrap;
    force dut.u_tx.r_frame_seq = 16'hFFFF;
    @(posedge clk); #1;
    release dut.u_tx.r_frame_seq;
    model_seq = 16'hFFFF;
    n_checks++;
    if (frame_seq !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %04h, expected FFFF", frame_seq); end
    push_packet(model_seq, 16'h0100);
    feed_scan(16'h0100, NUM_CH);
    wait_drain("wrap");
    model_seq++;
    n_checks++;
    if (frame_seq !== 16'h0000) begin n_fail++; $display("FAIL wrap_seq: got %04h, expected 0000", frame_seq); end
  endtask

  task automatic test_rst_mid;
    mon_en    = 1'b0;
    out_ready = 1'b0;
    feed_scan(16'h0100, NUM_CH);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0100_0101) begin
      n_fail++;
      $display("FAIL rst_mid_data_state: got valid=%b data=%08h, expected valid=1 data=01000101", out_valid, out_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, expected 0", out_valid); end
    n_checks++;
    if (frame_seq !== 16'h0 || drop_count !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_counters: got seq=%04h drop=%04h, expected 0/0", frame_seq, drop_count);
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    model_seq = '0;
    push_packet(model_seq, 16'h0300);
    feed_scan(16'h0300, NUM_CH);
    wait_drain("rst_mid");
    model_seq++;
    n_checks++;
    if (frame_seq !== model_seq) begin n_fail++; $display("FAIL rst_mid_seq: got %04h, expected %04h", frame_seq, model_seq); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_realign();
    test_seq_wrap();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
